// File: rtl/turn_move_ctrl.sv
// Button-driven N-player turn sequencer: debounced step buttons move tokens in turn order, with win detection.
// Optional turn_done timeout is built only when TURN_TIMEOUT_EN is defined.
module turn_move_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_STEP_BTNS   = 3,
    parameter int TILE_SPACING    = 60,
    parameter int START_X         = 20,
    parameter int NUM_TILES       = 10,
    parameter int OVERSHOOT_CLAMP = 0,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 50_000_000,
    localparam int PID_W          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk_100mhz,
    input  logic                      btn_reset,
    input  logic [NUM_STEP_BTNS-1:0]  btn_step,
    input  logic                      turn_done,
    output logic [NUM_PLAYERS*10-1:0] pos_x,
    output logic                      pos_valid,
    output logic [PID_W-1:0]          active_player,
    output logic                      winner_valid,
    output logic [PID_W-1:0]          winner_id,
    output logic                      timeout_flag,
    output logic [3:0]                led
);

    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      FLAG     = 4'(NUM_TILES);
    localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PLAYERS - 1);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_bad_players
        $error("NUM_PLAYERS must be 2..8");
    end
    if (NUM_TILES > 15 || START_X + NUM_TILES * TILE_SPACING > 1023) begin : g_bad_geometry
        $error("board geometry does not fit the 4-bit tile / 10-bit pixel fields");
    end
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_WAIT, S_NEXT, S_WIN} state_t;

    function automatic logic [9:0] tile_to_x(input logic [3:0] t);
        return 10'(START_X + TILE_SPACING * int'(t));
    endfunction

    logic [NUM_STEP_BTNS-1:0] sync1_q, sync2_q, deb_q, deb_prev_q, press;
    logic [DB_W-1:0]          db_cnt_q [NUM_STEP_BTNS];

    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NUM_STEP_BTNS; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= btn_step;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NUM_STEP_BTNS; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        deb_q[i]    <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Lowest-index button wins when several debounce in the same cycle.
    logic       press_any;
    logic [4:0] step_d;
    always_comb begin
        press_any = 1'b0;
        step_d    = '0;
        for (int i = NUM_STEP_BTNS - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_any = 1'b1;
                step_d    = 5'(i + 1);
            end
        end
    end

    state_t           state_q;
    logic [3:0]       tile_q [NUM_PLAYERS];
    logic [9:0]       pos_q  [NUM_PLAYERS];
    logic             pos_valid_q, winner_valid_q;
    logic [PID_W-1:0] active_player_q, winner_id_q, next_pid;
    logic [3:0]       led_q, cur_tile, tile_d;
    logic [4:0]       sum_d;
    logic             fits, accept, wait_done;

    assign cur_tile = tile_q[active_player_q];
    assign sum_d    = {1'b0, cur_tile} + step_d;
    assign fits     = (sum_d <= 5'(NUM_TILES));
    assign accept   = press_any && (fits || OVERSHOOT_CLAMP != 0);
    assign tile_d   = fits ? sum_d[3:0] : FLAG;
    assign next_pid = (active_player_q == LAST_PID) ? '0 : active_player_q + 1'b1;

`ifdef TURN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_flag_q, tmo_hit;

    assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counter is cleared in MOVE so every WAIT starts from zero.
    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            if (state_q == S_MOVE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_WAIT && !turn_done && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_hit && !turn_done) timeout_flag_q <= 1'b1;
        end
    end

    assign wait_done    = turn_done | tmo_hit;
    assign timeout_flag = timeout_flag_q;
`else
    assign wait_done    = turn_done;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            state_q         <= S_IDLE;
            pos_valid_q     <= 1'b0;
            active_player_q <= '0;
            winner_valid_q  <= 1'b0;
            winner_id_q     <= '0;
            led_q           <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                tile_q[p] <= '0;
                pos_q[p]  <= tile_to_x(4'd0);
            end
        end else begin
            pos_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tile_q[active_player_q] <= tile_d;
                        pos_q[active_player_q]  <= tile_to_x(tile_d);
                        led_q                   <= tile_d;
                        pos_valid_q             <= 1'b1;
                        state_q                 <= S_MOVE;
                    end
                end
                S_MOVE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (wait_done) begin
                        if (cur_tile == FLAG) begin
                            winner_valid_q <= 1'b1;
                            winner_id_q    <= active_player_q;
                            state_q        <= S_WIN;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    active_player_q <= next_pid;
                    led_q           <= tile_q[next_pid];
                    state_q         <= S_IDLE;
                end
                S_WIN:   state_q <= S_WIN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pos
        assign pos_x[10*p +: 10] = pos_q[p];
    end

    assign pos_valid     = pos_valid_q;
    assign active_player = active_player_q;
    assign winner_valid  = winner_valid_q;
    assign winner_id     = winner_id_q;
    assign led           = led_q;

endmodule
